vga_scanout: RTL and testbench
==============================

# vga_scanout

Display end of the 160x120 framebuffer path. Accepts pixel plot requests from drawing blocks (the same x/y/color/plot form the screen-clear and draw sweepers produce) and turns them into writes on the framebuffer RAM write port. Independently generates 640x480@60 VGA timing, reads the framebuffer at 4x4 pixel replication and drives registered RGB444 and sync outputs. Sits between the drawing logic and the external dual-port frame RAM (synchronous read, 1-cycle latency).

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch

- clk  input  1  25 MHz pixel clock
- reset  input  1  asynchronous, active-high
- CounterX  input  8  plot x coordinate, 0..159 valid
- CounterY  input  8  plot y coordinate, 0..119 valid
- plot  input  1  write request, one pixel per cycle while high
- color  input  12  plot color {R,G,B} 4 bits each
- wr_addr  output  15  frame RAM write address
- wr_data  output  12  frame RAM write data
- wr_en  output  1  frame RAM write enable
- rd_addr  output  15  frame RAM read address (combinational from counters)
- rd_data  input  12  frame RAM read data, valid one cycle after rd_addr
- vga_r, vga_g, vga_b  output  4 each  pixel color
- vga_hs  output  1  hsync, active low
- vga_vs  output  1  vsync, active low
- vga_blank_n  output  1  high during visible area
- frame_done  output  1  one-cycle pulse at start of each frame

## Operation
- Write path: each cycle with plot=1 and CounterX<160 and CounterY<120, register wr_addr = CounterX + CounterY*160 (15-bit, computed as x + (y<<7) + (y<<5)), wr_data = color, wr_en=1 next cycle. Out-of-range coordinates dropped: wr_en=0. plot=0: wr_en=0, wr_addr/wr_data hold.
- Timing counters: h_cnt 0..799 (wrap to 0), v_cnt 0..524, v_cnt increments when h_cnt wraps, wraps to 0 after 524 at h_cnt wrap.
- Visible: h_cnt<640 and v_cnt<480. rd_addr = (h_cnt>>2) + (v_cnt>>2)*160 when visible, else 0.
- hsync active (low) for h_cnt in [656,751]; vsync active (low) for v_cnt in [490,491].
- Stage 1 register: visible, hs, vs delayed one cycle (aligned to rd_data). Stage 2 register: vga_r/g/b = rd_data fields if delayed visible else 0; vga_hs, vga_vs, vga_blank_n from stage 1.
- frame_done registered: high for exactly the cycle in which counters are at (0,0) after a wrap from (799,524); not asserted on first cycle after reset.
- Write and read paths fully independent; simultaneous write to the address being read returns RAM-defined data (no forwarding).

## Timing
- Reset (async, immediate): h_cnt=v_cnt=0, wr_en=0, wr_addr=0, wr_data=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_done=0, all pipeline stages to inactive values.
- Reset mid-frame: counters restart at (0,0) on first edge after release; no partial sync pulse extension beyond deassert values.
- Plot to wr_en: 1 cycle.
- Counter state to pins: 2 cycles for RGB, hs, vs and blank_n alike (all aligned).
- Line period 800 clocks; frame 525 lines = 420000 clocks.
- hsync low 96 clocks; vsync low 2 lines = 1600 clocks.

## Test plan
- Reset release, run 2 lines -> vga_hs first falls 658 clocks after release (counter 656 + 2 latency), low 96 clocks, period 800; vga_blank_n high for 640 clocks per line.
- plot=1, CounterX=159, CounterY=119, color=12'hF0A -> next cycle wr_en=1, wr_addr=19199, wr_data=12'hF0A; CounterX=160 or CounterY=120 -> wr_en=0.
- Counters at h=8, v=4 -> rd_addr=162; h=639, v=479 -> rd_addr=19199; h=640 -> rd_addr=0.
- RAM model returns rd_data=12'h5A3 for address 162 -> vga_r=5, g=A, b=3 two cycles after h_cnt=8,v=4; RGB=0 throughout blanking regardless of rd_data.
- Run 2 full frames -> frame_done pulses exactly once per 420000 clocks, none on first post-reset cycle; vga_vs low 1600 clocks starting at v=490.
- Assert reset at h=300, v=200 mid-frame -> all outputs at reset values immediately; after release timing identical to first scenario.

Source files
------------

// File: rtl/vga_scanout_if.sv
// Framebuffer-side bus for vga_scanout.
// Carries the plot request stream coming from the drawing blocks and the
// write/read ports of the external dual-port frame RAM.
//   master : the scanout block (consumes plot requests, drives both RAM ports)
//   slave  : the environment (drawing sweepers plus the frame RAM)
// Signals:
//   CounterX/CounterY [7:0]  plot coordinate
//   plot                     one pixel write request per cycle while high
//   color [11:0]             {R,G,B} 4 bits each
//   wr_addr/wr_data/wr_en    RAM write port
//   rd_addr/rd_data          RAM read port, rd_data valid one cycle after rd_addr
interface vga_scanout_if;
    logic [7:0]  CounterX;
    logic [7:0]  CounterY;
    logic        plot;
    logic [11:0] color;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_en;
    logic [14:0] rd_addr;
    logic [11:0] rd_data;

    modport master (
        input  CounterX, CounterY, plot, color,
        output wr_addr, wr_data, wr_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        output CounterX, CounterY, plot, color,
        input  wr_addr, wr_data, wr_en,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/vga_scanout.sv
// Display end of the 160x120 framebuffer path.
// Turns plot requests into frame RAM writes and, independently, generates
// 640x480@60 VGA timing, reads the framebuffer with 4x4 pixel replication and
// drives registered RGB444, sync and blank outputs.
// Ports:
//   clk          25 MHz pixel clock
//   reset        asynchronous, active-high
//   bus          plot stream in, frame RAM write/read ports out (see vga_scanout_if)
//   vga_r/g/b    pixel color, 0 outside the visible area
//   vga_hs       hsync, active low
//   vga_vs       vsync, active low
//   vga_blank_n  high during the visible area
//   frame_done   one-cycle pulse when the counters return to (0,0)
module vga_scanout #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic          clk,
    input  logic          reset,
    vga_scanout_if.master bus,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank_n,
    output logic          frame_done
);

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned PIX_W  = 12;
    localparam int unsigned FB_W   = 160;
    localparam int unsigned FB_H   = 120;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [7:0]       X_LIMIT    = 8'(FB_W);
    localparam logic [7:0]       Y_LIMIT    = 8'(FB_H);

    // Raster position
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;

    // Position decode
    logic              h_last_c;
    logic              v_last_c;
    logic              visible_c;
    logic              hs_c;
    logic              vs_c;
    logic [ADDR_W-1:0] rd_addr_c;

    // Plot decode
    logic              plot_ok_c;
    logic [ADDR_W-1:0] plot_addr_c;

    // Stage 1: timing flags aligned with rd_data
    logic              vis_d1;
    logic              hs_d1;
    logic              vs_d1;

    //------------------------------------------------------------------
    // Write path
    //------------------------------------------------------------------

    // Accept only on-screen coordinates; address = x + y*160 via shifts.
    always_comb begin
        plot_ok_c   = bus.plot && (bus.CounterX < X_LIMIT) && (bus.CounterY < Y_LIMIT);
        plot_addr_c = ADDR_W'(bus.CounterX)
                    + (ADDR_W'(bus.CounterY) << 7)
                    + (ADDR_W'(bus.CounterY) << 5);
    end

    // Address/data hold their last accepted value when nothing is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= plot_ok_c;
            if (plot_ok_c) begin
                bus.wr_addr <= plot_addr_c;
                bus.wr_data <= bus.color;
            end
        end
    end

    //------------------------------------------------------------------
    // Timing generator
    //------------------------------------------------------------------

    // Line/frame position decode; sync levels are active low.
    always_comb begin
        h_last_c  = (h_cnt == H_LAST);
        v_last_c  = (v_cnt == V_LAST);
        visible_c = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        hs_c      = !((h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END));
        vs_c      = !((v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END));
    end

    // Raster counters; frame_done marks the cycle the counters sit at (0,0)
    // after wrapping, so the reset-origin cycle never pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= h_last_c && v_last_c;
            if (h_last_c) begin
                h_cnt <= '0;
                v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    //------------------------------------------------------------------
    // Read path
    //------------------------------------------------------------------

    // 4x4 replication: framebuffer cell = (h/4, v/4); parked at 0 in blanking.
    always_comb begin
        rd_addr_c = '0;
        if (visible_c) begin
            rd_addr_c = ADDR_W'(h_cnt[CNT_W-1:2])
                      + (ADDR_W'(v_cnt[CNT_W-1:2]) << 7)
                      + (ADDR_W'(v_cnt[CNT_W-1:2]) << 5);
        end
    end

    assign bus.rd_addr = rd_addr_c;

    // Stage 1: delay timing flags by the RAM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis_d1 <= 1'b0;
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
        end else begin
            vis_d1 <= visible_c;
            hs_d1  <= hs_c;
            vs_d1  <= vs_c;
        end
    end

    // Stage 2: output registers; color forced to black outside the visible area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_r       <= vis_d1 ? bus.rd_data[PIX_W-1:8] : 4'h0;
            vga_g       <= vis_d1 ? bus.rd_data[7:4]       : 4'h0;
            vga_b       <= vis_d1 ? bus.rd_data[3:0]       : 4'h0;
            vga_hs      <= hs_d1;
            vga_vs      <= vs_d1;
            vga_blank_n <= vis_d1;
        end
    end

    //------------------------------------------------------------------
    // Invariants
    //------------------------------------------------------------------

    // Counters stay inside the frame.
    assert property (@(posedge clk) disable iff (reset)
        (h_cnt <= H_LAST) && (v_cnt <= V_LAST));

    // The frame pulse only ever coincides with the raster origin.
    assert property (@(posedge clk) disable iff (reset)
        frame_done |-> ((h_cnt == '0) && (v_cnt == '0)));

    // Writes never land outside the 160x120 framebuffer.
    assert property (@(posedge clk) disable iff (reset)
        bus.wr_en |-> (bus.wr_addr < ADDR_W'(FB_W * FB_H)));

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (full 640x480 timing and a shrunken
// timing so whole frames fit in a short run) share clock, reset and a
// randomized plot stream. Expected pins are computed from the absolute cycle
// count since reset release; a ROM stands in for the frame RAM read port.
module tb_vga_scanout;

    typedef struct packed {
        int unsigned hv; int unsigned hf; int unsigned hs; int unsigned hb;
        int unsigned vv; int unsigned vf; int unsigned vs; int unsigned vb;
    } timing_t;

    typedef struct packed {
        logic [14:0] rd_addr;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        frame_done;
    } exp_t;

    localparam timing_t T_A = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t T_B = '{40, 4, 8, 4, 12, 2, 2, 3};

    logic clk;
    logic reset;

    logic        plot_v;
    logic [7:0]  x_v;
    logic [7:0]  y_v;
    logic [11:0] col_v;

    vga_scanout_if bus_a ();
    vga_scanout_if bus_b ();

    logic [3:0] vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;
    logic       vga_hs_a, vga_vs_a, vga_blank_n_a, frame_done_a;
    logic       vga_hs_b, vga_vs_b, vga_blank_n_b, frame_done_b;

    assign bus_a.plot = plot_v;  assign bus_b.plot = plot_v;
    assign bus_a.CounterX = x_v; assign bus_b.CounterX = x_v;
    assign bus_a.CounterY = y_v; assign bus_b.CounterY = y_v;
    assign bus_a.color = col_v;  assign bus_b.color = col_v;

    vga_scanout u_a (
        .clk(clk), .reset(reset), .bus(bus_a),
        .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
        .vga_hs(vga_hs_a), .vga_vs(vga_vs_a),
        .vga_blank_n(vga_blank_n_a), .frame_done(frame_done_a)
    );

    vga_scanout #(
        .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_b (
        .clk(clk), .reset(reset), .bus(bus_b),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
        .vga_hs(vga_hs_b), .vga_vs(vga_vs_b),
        .vga_blank_n(vga_blank_n_b), .frame_done(frame_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n;          // clock edges since reset release
    logic        chk_on = 1'b0;
    logic        rand_on = 1'b0;
    int unsigned phase = 0;

    // Framebuffer contents seen by the read port.
    function automatic logic [11:0] pat(input logic [14:0] a);
        if (a == 15'd162) return 12'h5A3;
        return 12'(a * 15'd7 + 15'd13);
    endfunction

    // Expected pins after n edges since release, straight from the raster rules.
    function automatic exp_t model(input timing_t t, input int unsigned cyc);
        int unsigned ht, vt, fr, c, h, v, p, ph, pv;
        exp_t e;
        ht = t.hv + t.hf + t.hs + t.hb;
        vt = t.vv + t.vf + t.vs + t.vb;
        fr = ht * vt;
        c  = cyc % fr;
        h  = c % ht;
        v  = c / ht;
        e.rd_addr    = (h < t.hv && v < t.vv) ? 15'((h / 4) + (v / 4) * 160) : 15'd0;
        e.frame_done = (cyc != 0) && (c == 0);
        e.rgb        = 12'h000;
        e.hs         = 1'b1;
        e.vs         = 1'b1;
        e.blank_n    = 1'b0;
        if (cyc >= 2) begin
            p  = (cyc - 2) % fr;
            ph = p % ht;
            pv = p / ht;
            if (ph < t.hv && pv < t.vv) begin
                e.blank_n = 1'b1;
                e.rgb     = pat(15'((ph / 4) + (pv / 4) * 160));
            end
            e.hs = !(ph >= t.hv + t.hf && ph < t.hv + t.hf + t.hs);
            e.vs = !(pv >= t.vv + t.vf && pv < t.vv + t.vf + t.vs);
        end
        return e;
    endfunction

    function automatic int unsigned qget(input int unsigned q[$], input int unsigned i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    // Cycle counter and read-port ROM.
    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    always @(posedge clk) begin
        bus_a.rd_data <= pat(bus_a.rd_addr);
        bus_b.rd_data <= pat(bus_b.rd_addr);
    end

    // Write-port reference: last accepted plot, x + 160*y.
    logic        m_wr_en;
    logic [14:0] m_wr_addr;
    logic [11:0] m_wr_data;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wr_en <= 1'b0; m_wr_addr <= '0; m_wr_data <= '0;
        end else if (plot_v && x_v < 8'd160 && y_v < 8'd120) begin
            m_wr_en   <= 1'b1;
            m_wr_addr <= 15'(int'(x_v) + int'(y_v) * 160);
            m_wr_data <= col_v;
        end else begin
            m_wr_en <= 1'b0;
        end
    end

    task automatic drive(input logic p, input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
        plot_v = p; x_v = x; y_v = y; col_v = c;
    endtask

    task automatic cmp_dut(input string tag, input exp_t e, input logic [14:0] rd,
                           input logic [11:0] rgb, input logic hs, input logic vs,
                           input logic bl, input logic fd, input logic we,
                           input logic [14:0] wa, input logic [11:0] wd);
        check({tag, "_rd_addr"}, 32'(rd), 32'(e.rd_addr));
        check({tag, "_rgb"}, 32'(rgb), 32'(e.rgb));
        check({tag, "_hs_vs_blank"}, 32'({hs, vs, bl}), 32'({e.hs, e.vs, e.blank_n}));
        check({tag, "_frame_done"}, 32'(fd), 32'(e.frame_done));
        check({tag, "_write_port"}, {4'h0, we, wa, wd}, {4'h0, m_wr_en, m_wr_addr, m_wr_data});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a_pins"}, 32'({vga_r_a, vga_g_a, vga_b_a, vga_hs_a, vga_vs_a, vga_blank_n_a, frame_done_a}),
              32'({12'h000, 1'b1, 1'b1, 1'b0, 1'b0}));
        check({tag, "_b_pins"}, 32'({vga_r_b, vga_g_b, vga_b_b, vga_hs_b, vga_vs_b, vga_blank_n_b, frame_done_b}),
              32'({12'h000, 1'b1, 1'b1, 1'b0, 1'b0}));
        check({tag, "_a_write"}, {4'h0, bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data}, 32'h0);
        check({tag, "_b_write"}, {4'h0, bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data}, 32'h0);
        check({tag, "_a_rd_addr"}, 32'(bus_a.rd_addr), 32'h0);
    endtask

    // Event records for timing measurements.
    int unsigned hs_fall_a[$], hs_rise_a[$], vs_fall_b[$], vs_rise_b[$], fd_b[$];
    int unsigned blank_cnt_a;
    logic        prev_hs_a, prev_vs_b;
    logic [14:0] snap_rd639, snap_rd640, snap_rd162;
    logic [11:0] snap_rgb162;

    task automatic clear_records();
        hs_fall_a.delete(); hs_rise_a.delete();
        vs_fall_b.delete(); vs_rise_b.delete(); fd_b.delete();
        blank_cnt_a = 0; prev_hs_a = 1'b1; prev_vs_b = 1'b1;
    endtask

    // Per-cycle compare against the model, plus event recording.
    initial begin : compare_proc
        exp_t ea, eb;
        forever begin
            @(negedge clk);
            if (chk_on && !reset) begin
                ea = model(T_A, n);
                eb = model(T_B, n);
                cmp_dut("a", ea, bus_a.rd_addr, {vga_r_a, vga_g_a, vga_b_a}, vga_hs_a, vga_vs_a,
                        vga_blank_n_a, frame_done_a, bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data);
                cmp_dut("b", eb, bus_b.rd_addr, {vga_r_b, vga_g_b, vga_b_b}, vga_hs_b, vga_vs_b,
                        vga_blank_n_b, frame_done_b, bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data);
                if (prev_hs_a && !vga_hs_a) hs_fall_a.push_back(n);
                if (!prev_hs_a && vga_hs_a) hs_rise_a.push_back(n);
                if (prev_vs_b && !vga_vs_b) vs_fall_b.push_back(n);
                if (!prev_vs_b && vga_vs_b) vs_rise_b.push_back(n);
                if (frame_done_b) fd_b.push_back(n);
                if (n >= 2 && n <= 801 && vga_blank_n_a) blank_cnt_a++;
                prev_hs_a = vga_hs_a;
                prev_vs_b = vga_vs_b;
                if (phase == 1) begin
                    if (n == 639)  snap_rd639  = bus_a.rd_addr;
                    if (n == 640)  snap_rd640  = bus_a.rd_addr;
                    if (n == 3208) snap_rd162  = bus_a.rd_addr;
                    if (n == 3210) snap_rgb162 = {vga_r_a, vga_g_a, vga_b_a};
                end
            end
        end
    end

    // Random plot stream.
    initial begin : driver_proc
        forever begin
            @(negedge clk);
            if (rand_on)
                drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 175)),
                      8'($urandom_range(0, 130)), 12'($urandom));
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached at n=%0d", n);
        $fatal(1, "time limit");
    end

    initial begin : main
        exp_t m;
        reset = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 12'h000);
        repeat (3) @(negedge clk);
        check_reset("por");
        clear_records();
        phase = 1;
        @(negedge clk);
        reset = 1'b0; chk_on = 1'b1; rand_on = 1'b1;

        // Directed plot boundaries.
        while (n < 1000) @(negedge clk);
        rand_on = 1'b0;
        drive(1'b1, 8'd159, 8'd119, 12'hF0A);
        @(negedge clk);
        check("plot_corner", {4'h0, bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data}, {4'h0, 1'b1, 15'd19199, 12'hF0A});
        drive(1'b1, 8'd160, 8'd5, 12'h123);
        @(negedge clk);
        check("plot_x160", {4'h0, bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data}, {4'h0, 1'b0, 15'd19199, 12'hF0A});
        drive(1'b1, 8'd5, 8'd120, 12'h456);
        @(negedge clk);
        check("plot_y120", 32'(bus_b.wr_en), 32'h0);
        drive(1'b0, 8'd3, 8'd3, 12'h789);
        @(negedge clk);
        check("plot_idle_hold", {4'h0, bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data}, {4'h0, 1'b0, 15'd19199, 12'hF0A});
        rand_on = 1'b1;

        // First-run timing.
        while (n < 3300) @(negedge clk);
        check("hs_first_fall", qget(hs_fall_a, 0), 658);
        check("hs_first_rise", qget(hs_rise_a, 0), 754);
        check("hs_second_fall", qget(hs_fall_a, 1), 1458);
        check("blank_per_line", blank_cnt_a, 640);
        check("rd_addr_h639", 32'(snap_rd639), 159);
        check("rd_addr_h640", 32'(snap_rd640), 0);
        check("rd_addr_h8_v4", 32'(snap_rd162), 162);
        check("rgb_h8_v4", 32'(snap_rgb162), 32'h5A3);
        check("frame_done_count", fd_b.size(), 3);
        check("frame_done_first", qget(fd_b, 0), 1064);
        check("frame_done_second", qget(fd_b, 1), 2128);
        check("vs_first_fall", qget(vs_fall_b, 0), 786);
        check("vs_first_rise", qget(vs_rise_b, 0), 898);

        // Mid-frame reset (shrunken instance at h=30, v=7).
        phase = 2;
        while (n < 3614) @(negedge clk);
        chk_on = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset("mid");
        clear_records();
        repeat (3) @(negedge clk);
        reset = 1'b0; chk_on = 1'b1;

        while (n < 2500) @(negedge clk);
        check("re_hs_first_fall", qget(hs_fall_a, 0), 658);
        check("re_hs_first_rise", qget(hs_rise_a, 0), 754);
        check("re_frame_done_count", fd_b.size(), 2);
        check("re_frame_done_first", qget(fd_b, 0), 1064);
        check("re_vs_first_fall", qget(vs_fall_b, 0), 786);
        chk_on = 1'b0;

        // Pin the model against hand-computed full-size values.
        m = model(T_A, 479 * 800 + 639);
        check("model_rd_corner", 32'(m.rd_addr), 19199);
        m = model(T_A, 420000);
        check("model_frame_done", 32'(m.frame_done), 1);
        m = model(T_A, 490 * 800 + 2);
        check("model_vs_low", 32'(m.vs), 0);
        m = model(T_A, 492 * 800 + 2);
        check("model_vs_high", 32'(m.vs), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
